rs_bank: RTL
============

Name: rs_bank

Overview:
- Parametrised reservation-station bank holding RS_NUM entries; generalises the single-entry RS slot.
- Adds multi-port CDB wakeup (CDB_NUM ports), internal free-entry allocation, and ready-entry selection for issue.
- Provides full/free-count backpressure and branch mask resolve/squash across all entries.
- Sits between dispatch/rename and one functional-unit issue port.

Parameters:
RS_NUM, 8, number of entries (power of 2, >=2)
CDB_NUM, 2, number of CDB broadcast ports
PRF_IDX_W, 6, physical register tag width
ROB_IDX_W, 5, ROB index width; stored field is ROB_IDX_W+1 bits
BR_MASK_W, 4, branch mask width
FU_SEL_W, 3, FU select width; 0 means no FU

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
disp_vld_i  in  1  dispatch request
disp_dest_tag_i  in  PRF_IDX_W  destination tag
disp_opa_tag_i  in  PRF_IDX_W  operand A tag
disp_opb_tag_i  in  PRF_IDX_W  operand B tag
disp_opa_rdy_i  in  1  operand A ready at rename
disp_opb_rdy_i  in  1  operand B ready at rename
disp_fu_sel_i  in  FU_SEL_W  FU select
disp_IR_i  in  32  instruction
disp_rob_idx_i  in  ROB_IDX_W+1  ROB index
disp_br_mask_i  in  BR_MASK_W  branch mask
cdb_vld_i  in  CDB_NUM  per-port CDB valid
cdb_tag_i  in  CDB_NUM*PRF_IDX_W  per-port tag; port k occupies bits [k*PRF_IDX_W +: PRF_IDX_W]
iss_stall_i  in  1  FU cannot accept this cycle
br_pred_correct_i  in  1  branch resolved correctly
br_recovery_i  in  1  branch mispredicted
br_tag_fix_i  in  BR_MASK_W  one-hot tag of the resolving branch
iss_vld_o  out  1  an instruction is presented for issue
iss_dest_tag_o, iss_opa_tag_o, iss_opb_tag_o  out  PRF_IDX_W each  issued tags
iss_fu_sel_o  out  FU_SEL_W  issued FU select
iss_IR_o  out  32  issued instruction
iss_rob_idx_o  out  ROB_IDX_W+1  issued ROB index
iss_br_mask_o  out  BR_MASK_W  issued mask, resolved bit already cleared
full_o  out  1  no free entry
free_cnt_o  out  $clog2(RS_NUM)+1  number of free entries

Behaviour:
- Reset (rst=0, asynchronous):
  - All entries free; all stored fields 0; fu_sel = 0.
  - full_o=0, free_cnt_o=RS_NUM, iss_vld_o=0, all iss_* outputs 0.
- full_o and free_cnt_o are combinational from registered valid bits only. A slot freed by this cycle's issue or squash counts as free from the next cycle.
- Dispatch:
  - If disp_vld_i and !full_o, load the lowest-index free entry at the clock edge.
  - If disp_vld_i while full_o=1, drop the request silently; upstream must stall on full_o.
- Dispatch wakeup bypass: operand rdy = disp_*_rdy_i OR (any cdb_vld_i[k] with cdb_tag_i[k] == disp tag).
- Dispatch mask handling:
  - If br_pred_correct_i, store disp_br_mask_i & ~br_tag_fix_i.
  - If br_recovery_i and (disp_br_mask_i & br_tag_fix_i) != 0, do not allocate.
- Wakeup: every valid entry sets opX_rdy when any valid CDB port tag matches opX_tag. All CDB_NUM ports are compared in parallel.
- Per-entry ready (combinational) = valid & opa_ok & opb_ok & !squash_this_cycle, where opX_ok = opX_rdy | (any CDB port matches opX_tag this cycle). Ready therefore includes same-cycle CDB wakeup.
- Select:
  - Grant goes to the lowest-index ready entry.
  - iss_vld_o = any entry ready.
  - iss_* show the granted entry's fields; they are 0 when iss_vld_o=0.
- Issue commit: when iss_vld_o and !iss_stall_i, free the granted entry at the edge. While stalled, the entry stays and the grant is recomputed next cycle.
- Branch resolve (correct): clear br_tag_fix_i in every entry's mask at the edge. iss_br_mask_o shows the cleared value in the same cycle.
- Branch recovery:
  - Free every valid entry with (br_mask & br_tag_fix_i) != 0 at the edge.
  - Such entries are excluded from select in the same cycle.
  - Squash takes priority over issue and wakeup.
- br_pred_correct_i and br_recovery_i are never asserted together.
- Simultaneous dispatch + issue + wakeup in one cycle are all honoured independently. Dispatch never targets the entry being issued in that cycle.
- Latency: dispatch at edge N → earliest iss_vld_o in the cycle after edge N.
- Free-entry priority and grant priority are both index-ascending. No age ordering is implied.

Test Plan:
- Reset then dispatch opa/opb_rdy=1, dest=5 → next cycle iss_vld_o=1, iss_dest_tag_o=5, free_cnt_o=7; no stall → free_cnt_o=8 after the edge.
- Dispatch opa_tag=9 not ready; cdb_vld_i=2'b10, cdb_tag port1=9 two cycles later → iss_vld_o=1 in that same CDB cycle.
- Dispatch with opa_tag=12 while CDB port0 broadcasts 12 → entry stored ready and issues the next cycle.
- Fill 8 entries, none ready → full_o=1, free_cnt_o=0; a 9th dispatch is dropped; after one wakeup+issue, full_o=0 the following cycle.
- Entries 0 and 3 ready, iss_stall_i=1 for 2 cycles → entry 0 presented and held; release → entry 0 freed, entry 3 presented next.
- Entries with masks 4'b0010, 4'b0100; br_recovery_i with fix=4'b0010 → first entry freed, excluded from issue that cycle; br_pred_correct_i fix=4'b0100 → second entry mask becomes 0.

Source files
------------

// File: rtl/rs_bank.sv
// rs_bank: multi-entry reservation station bank for one functional-unit issue
// port. Holds RS_NUM instructions, wakes operands from CDB_NUM broadcast ports,
// allocates the lowest free slot on dispatch, and issues the lowest ready slot.
// Branch resolution clears mask bits; branch recovery squashes dependent entries.
module rs_bank #(
    parameter int RS_NUM    = 8,
    parameter int CDB_NUM   = 2,
    parameter int PRF_IDX_W = 6,
    parameter int ROB_IDX_W = 5,
    parameter int BR_MASK_W = 4,
    parameter int FU_SEL_W  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           disp_vld_i,
    input  logic [PRF_IDX_W-1:0]           disp_dest_tag_i,
    input  logic [PRF_IDX_W-1:0]           disp_opa_tag_i,
    input  logic [PRF_IDX_W-1:0]           disp_opb_tag_i,
    input  logic                           disp_opa_rdy_i,
    input  logic                           disp_opb_rdy_i,
    input  logic [FU_SEL_W-1:0]            disp_fu_sel_i,
    input  logic [31:0]                    disp_IR_i,
    input  logic [ROB_IDX_W:0]             disp_rob_idx_i,
    input  logic [BR_MASK_W-1:0]           disp_br_mask_i,
    input  logic [CDB_NUM-1:0]             cdb_vld_i,
    input  logic [CDB_NUM*PRF_IDX_W-1:0]   cdb_tag_i,
    input  logic                           iss_stall_i,
    input  logic                           br_pred_correct_i,
    input  logic                           br_recovery_i,
    input  logic [BR_MASK_W-1:0]           br_tag_fix_i,
    output logic                           iss_vld_o,
    output logic [PRF_IDX_W-1:0]           iss_dest_tag_o,
    output logic [PRF_IDX_W-1:0]           iss_opa_tag_o,
    output logic [PRF_IDX_W-1:0]           iss_opb_tag_o,
    output logic [FU_SEL_W-1:0]            iss_fu_sel_o,
    output logic [31:0]                    iss_IR_o,
    output logic [ROB_IDX_W:0]             iss_rob_idx_o,
    output logic [BR_MASK_W-1:0]           iss_br_mask_o,
    output logic                           full_o,
    output logic [$clog2(RS_NUM):0]        free_cnt_o
);

    localparam int IDX_W = $clog2(RS_NUM);
    localparam int CNT_W = $clog2(RS_NUM) + 1;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] dest_tag;
        logic [PRF_IDX_W-1:0] opa_tag;
        logic [PRF_IDX_W-1:0] opb_tag;
        logic                 opa_rdy;
        logic                 opb_rdy;
        logic [FU_SEL_W-1:0]  fu_sel;
        logic [31:0]          ir;
        logic [ROB_IDX_W:0]   rob_idx;
        logic [BR_MASK_W-1:0] br_mask;
    } rs_entry_t;

    // True when any valid CDB port broadcasts the given tag this cycle.
    function automatic logic cdb_hit(
        input logic [PRF_IDX_W-1:0]         tag,
        input logic [CDB_NUM-1:0]           vld,
        input logic [CDB_NUM*PRF_IDX_W-1:0] tags
    );
        cdb_hit = 1'b0;
        for (int k = 0; k < CDB_NUM; k++) begin
            if (vld[k] && (tags[k*PRF_IDX_W +: PRF_IDX_W] == tag)) cdb_hit = 1'b1;
        end
    endfunction

    logic [RS_NUM-1:0] valid_q;
    rs_entry_t         ent_q [RS_NUM];

    logic [RS_NUM-1:0] opa_hit, opb_hit, squash, ready;
    logic              grant_vld;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  alloc_idx;
    logic [CNT_W-1:0]  free_cnt;
    logic              issue_fire;
    logic              disp_fire;
    rs_entry_t         disp_entry;

    // Per-entry CDB match, squash and ready (same-cycle wakeup counts as ready).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        opa_hit = '0;
        opb_hit = '0;
        squash  = '0;
        ready   = '0;
        for (int i = 0; i < RS_NUM; i++) begin
            opa_hit[i] = cdb_hit(ent_q[i].opa_tag, cdb_vld_i, cdb_tag_i);
            opb_hit[i] = cdb_hit(ent_q[i].opb_tag, cdb_vld_i, cdb_tag_i);
            squash[i]  = valid_q[i] & br_recovery_i & (|(ent_q[i].br_mask & br_tag_fix_i));
            ready[i]   = valid_q[i] & (ent_q[i].opa_rdy | opa_hit[i])
                                    & (ent_q[i].opb_rdy | opb_hit[i]) & ~squash[i];
        end
    end

    // Lowest-index ready entry wins the issue grant; scan downward so the last hit is lowest.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (ready[i]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free entry and free count, from registered valid bits only.
    always_comb begin
        alloc_idx = '0;
        free_cnt  = '0;
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IDX_W'(i);
            free_cnt = free_cnt + CNT_W'(~valid_q[i]);
        end
    end

    assign full_o     = (free_cnt == '0);
    assign free_cnt_o = free_cnt;
    assign issue_fire = grant_vld & ~iss_stall_i;

    // Dispatch payload with CDB bypass on operands and branch-resolve mask cleanup.
    always_comb begin
        disp_entry          = '0;
        disp_entry.dest_tag = disp_dest_tag_i;
        disp_entry.opa_tag  = disp_opa_tag_i;
        disp_entry.opb_tag  = disp_opb_tag_i;
        disp_entry.opa_rdy  = disp_opa_rdy_i | cdb_hit(disp_opa_tag_i, cdb_vld_i, cdb_tag_i);
        disp_entry.opb_rdy  = disp_opb_rdy_i | cdb_hit(disp_opb_tag_i, cdb_vld_i, cdb_tag_i);
        disp_entry.fu_sel   = disp_fu_sel_i;
        disp_entry.ir       = disp_IR_i;
        disp_entry.rob_idx  = disp_rob_idx_i;
        disp_entry.br_mask  = br_pred_correct_i ? (disp_br_mask_i & ~br_tag_fix_i)
                                                : disp_br_mask_i;
        disp_fire = disp_vld_i & ~full_o
                  & ~(br_recovery_i & (|(disp_br_mask_i & br_tag_fix_i)));
    end

    // Issue port shows the granted entry, with a resolving branch bit already cleared.
    always_comb begin
        iss_vld_o      = grant_vld;
        iss_dest_tag_o = '0;
        iss_opa_tag_o  = '0;
        iss_opb_tag_o  = '0;
        iss_fu_sel_o   = '0;
        iss_IR_o       = '0;
        iss_rob_idx_o  = '0;
        iss_br_mask_o  = '0;
        if (grant_vld) begin
            iss_dest_tag_o = ent_q[grant_idx].dest_tag;
            iss_opa_tag_o  = ent_q[grant_idx].opa_tag;
            iss_opb_tag_o  = ent_q[grant_idx].opb_tag;
            iss_fu_sel_o   = ent_q[grant_idx].fu_sel;
            iss_IR_o       = ent_q[grant_idx].ir;
            iss_rob_idx_o  = ent_q[grant_idx].rob_idx;
            iss_br_mask_o  = br_pred_correct_i ? (ent_q[grant_idx].br_mask & ~br_tag_fix_i)
                                               : ent_q[grant_idx].br_mask;
        end
    end

    // Entry state: squash beats issue beats wakeup/resolve; free slots accept dispatch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            // NOTE: the entry array is reset because issue outputs and fields must read 0 after reset.
            for (int i = 0; i < RS_NUM; i++) ent_q[i] <= '0;
        end else begin
            for (int i = 0; i < RS_NUM; i++) begin
                if (valid_q[i]) begin
                    // NOTE: state updates use <= so all entries see pre-edge values of each other.
                    if (squash[i] || (issue_fire && (grant_idx == IDX_W'(i)))) begin
                        valid_q[i] <= 1'b0;
                    end else begin
                        if (opa_hit[i]) ent_q[i].opa_rdy <= 1'b1;
                        if (opb_hit[i]) ent_q[i].opb_rdy <= 1'b1;
                        if (br_pred_correct_i)
                            ent_q[i].br_mask <= ent_q[i].br_mask & ~br_tag_fix_i;
                    end
                end else if (disp_fire && (alloc_idx == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    ent_q[i]   <= disp_entry;
                end
            end
        end
    end

endmodule
